// File: rtl/rr_arbiter_param.sv
// Round-robin bus arbiter for NUM_REQ masters: lock-until-release grants, registered one-hot grant and ID.
// Define RRA_HOLD_LIMIT_EN to preempt a holder after HOLD_MAX contended cycles.
module rr_arbiter_param #(
    parameter int NUM_REQ  = 4,
    parameter int HOLD_MAX = 16,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               preempt
);

    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ACT_STAY,
        ACT_GRANT,
        ACT_HOLD,
        ACT_FREE
    } act_e;

    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_d;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    gnt_id_d;
    logic               gnt_valid_q;
    logic               gnt_valid_d;
    logic               preempt_q;
    logic               preempt_d;
    logic [ID_W-1:0]    last_q;
    logic [ID_W-1:0]    last_d;

    logic [NUM_REQ-1:0] cand_s;
    logic               win_found_s;
    logic [ID_W-1:0]    win_idx_s;
    logic [ID_W-1:0]    scan_idx_s;
    logic [NUM_REQ-1:0] win_onehot_s;
    logic               own_req_s;
    logic               limit_hit_s;
    act_e               act_s;

`ifdef RRA_HOLD_LIMIT_EN
    localparam int HC_W = $clog2(HOLD_MAX);
    localparam logic [HC_W-1:0] HC_SAT = HC_W'(HOLD_MAX - 1);

    logic [HC_W-1:0] hcnt_q;
    logic [HC_W-1:0] hcnt_d;
`endif

    // Circular search for the next winner, starting just after the last winner.
    // The current owner is masked out so a preemption hands off to someone else.
    always_comb begin
        cand_s      = req & ~gnt_q;
        win_found_s = 1'b0;
        win_idx_s   = {ID_W{1'b0}};
        scan_idx_s  = last_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (scan_idx_s == LAST_IDX) begin
                scan_idx_s = {ID_W{1'b0}};
            end else begin
                scan_idx_s = scan_idx_s + 1'b1;
            end
            if (!win_found_s && cand_s[scan_idx_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = scan_idx_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
        win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s;
        own_req_s    = req[gnt_id_q];
    end

    // Hold-limit condition: saturated tenure while someone else is waiting.
    always_comb begin
`ifdef RRA_HOLD_LIMIT_EN
        limit_hit_s = (hcnt_q == HC_SAT) && win_found_s;
`else
        limit_hit_s = 1'b0;
`endif
    end

    // Decide this edge's action from the current ownership and requests.
    always_comb begin
        act_s = ACT_STAY;
        if (gnt_q == {NUM_REQ{1'b0}}) begin
            if (win_found_s) begin
                act_s = ACT_GRANT;
            end else begin
                act_s = ACT_STAY;
            end
        end else if (!own_req_s) begin
            if (win_found_s) begin
                act_s = ACT_GRANT;
            end else begin
                act_s = ACT_FREE;
            end
        end else if (limit_hit_s) begin
            act_s = ACT_GRANT;
        end else begin
            act_s = ACT_HOLD;
        end
    end

    // Next-state values for grant, pointer, preempt flag and hold counter.
    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        preempt_d = 1'b0;
`ifdef RRA_HOLD_LIMIT_EN
        hcnt_d    = hcnt_q;
`endif
        case (act_s)
            ACT_GRANT: begin
                gnt_d     = win_onehot_s;
                gnt_id_d  = win_idx_s;
                last_d    = win_idx_s;
                // A grant issued while the owner still requests is a preemption.
                preempt_d = (gnt_q != {NUM_REQ{1'b0}}) && own_req_s;
`ifdef RRA_HOLD_LIMIT_EN
                hcnt_d    = {HC_W{1'b0}};
`endif
            end
            ACT_HOLD: begin
                gnt_d    = gnt_q;
                gnt_id_d = gnt_id_q;
`ifdef RRA_HOLD_LIMIT_EN
                if (hcnt_q != HC_SAT) begin
                    hcnt_d = hcnt_q + 1'b1;
                end else begin
                    hcnt_d = hcnt_q;
                end
`endif
            end
            ACT_FREE: begin
                gnt_d    = {NUM_REQ{1'b0}};
                gnt_id_d = {ID_W{1'b0}};
            end
            ACT_STAY: begin
                gnt_d    = gnt_q;
                gnt_id_d = gnt_id_q;
            end
            default: begin
                gnt_d    = {NUM_REQ{1'b0}};
                gnt_id_d = {ID_W{1'b0}};
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    // State registers with synchronous reset; last points at NUM_REQ-1 so req[0] wins first.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_q       <= {NUM_REQ{1'b0}};
            gnt_id_q    <= {ID_W{1'b0}};
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            last_q      <= LAST_IDX;
        end else begin
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            last_q      <= last_d;
        end
    end

`ifdef RRA_HOLD_LIMIT_EN
    // Tenure counter, cleared on every new grant and saturating while held.
    always_ff @(posedge clock) begin
        if (reset) begin
            hcnt_q <= {HC_W{1'b0}};
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Scoreboard bench for rr_arbiter_param (NUM_REQ=4, HOLD_MAX=4); expectations follow RRA_HOLD_LIMIT_EN.
module tb_rr_arbiter_param;

    localparam int HM = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    int total = 0;
    int bad   = 0;

    logic [3:0] q_gnt[$];
    logic       q_pre[$];
    string      q_name[$];

    rr_arbiter_param #(
        .NUM_REQ  (4),
        .HOLD_MAX (HM)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clock = ~clock;

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                       input logic ep, input string nm);
        @(negedge clock);
        reset = r;
        req   = rq;
        q_gnt.push_back(eg);
        q_pre.push_back(ep);
        q_name.push_back(nm);
    endtask

    initial begin : monitor
        logic [3:0] eg;
        logic       ep;
        string      nm;
        forever begin
            @(posedge clock);
            #1;
            if (q_gnt.size() > 0) begin
                eg = q_gnt.pop_front();
                ep = q_pre.pop_front();
                nm = q_name.pop_front();
                total++;
                if (gnt !== eg || gnt_id !== enc(eg) || gnt_valid !== (|eg) || preempt !== ep) begin
                    bad++;
                    $display("FAIL %s: got gnt=%b id=%0d valid=%b preempt=%b, want gnt=%b id=%0d valid=%b preempt=%b",
                             nm, gnt, gnt_id, gnt_valid, preempt, eg, enc(eg), |eg, ep);
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] eg;
        logic       ep;
        int         wait_cnt;

        // 1: reset held with all requests, then master 0 wins first
        for (int i = 0; i < 5; i++) cyc(1'b1, 4'b1111, 4'b0000, 1'b0, "t1_reset");
        cyc(1'b0, 4'b1111, 4'b0001, 1'b0, "t1_first");
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, "t1_drop");

        // 2: single requester for three cycles
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, 4'b0100, 1'b0, "t2_hold");
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, "t2_release");

        // 3: rotation with release one cycle after grant, no bubbles
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, "t3_reset");
        cyc(1'b0, 4'b1111, 4'b0001, 1'b0, "t3_g0");
        cyc(1'b0, 4'b1110, 4'b0010, 1'b0, "t3_g1");
        cyc(1'b0, 4'b1101, 4'b0100, 1'b0, "t3_g2");
        cyc(1'b0, 4'b1011, 4'b1000, 1'b0, "t3_g3");
        cyc(1'b0, 4'b0111, 4'b0001, 1'b0, "t3_g0_again");
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, "t3_idle");

        // 4: two steady requesters
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, "t4_reset");
        for (int i = 1; i <= 10; i++) begin
`ifdef RRA_HOLD_LIMIT_EN
            eg = (((i - 1) / HM) % 2 == 0) ? 4'b0001 : 4'b0010;
            ep = (i > 1) && ((i - 1) % HM == 0);
`else
            eg = 4'b0001;
            ep = 1'b0;
`endif
            cyc(1'b0, 4'b0011, eg, ep, "t4_contend");
        end
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, "t4_idle");

        // 5: lone holder is never preempted; a late competitor takes over
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, "t5_reset");
        for (int i = 0; i < 20; i++) cyc(1'b0, 4'b1000, 4'b1000, 1'b0, "t5_lone");
`ifdef RRA_HOLD_LIMIT_EN
        cyc(1'b0, 4'b1001, 4'b0001, 1'b1, "t5_handoff");
        cyc(1'b0, 4'b1001, 4'b0001, 1'b0, "t5_after");
`else
        cyc(1'b0, 4'b1001, 4'b1000, 1'b0, "t5_handoff");
        cyc(1'b0, 4'b1001, 4'b1000, 1'b0, "t5_after");
`endif
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, "t5_idle");

        // 6: reset mid-tenure, then master 0 wins
        cyc(1'b1, 4'b0000, 4'b0000, 1'b0, "t6_reset_a");
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0, "t6_own2");
        cyc(1'b0, 4'b0100, 4'b0100, 1'b0, "t6_own2_hold");
        cyc(1'b1, 4'b0100, 4'b0000, 1'b0, "t6_reset_mid");
        cyc(1'b0, 4'b1111, 4'b0001, 1'b0, "t6_first");
        cyc(1'b0, 4'b0000, 4'b0000, 1'b0, "t6_idle");

        wait_cnt = 0;
        while (q_gnt.size() > 0 && wait_cnt < 10) begin
            @(negedge clock);
            wait_cnt++;
        end
        if (q_gnt.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", q_gnt.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_param.md
# rr_arbiter_param

Parametrised round-robin bus arbiter: the next generation of the 4-requester lock-until-release arbiter, generalised to NUM_REQ requesters with vector ports, a registered one-hot grant plus encoded grant ID, and an optional hold-limit that preempts a requester that keeps the bus too long while others wait. It sits between NUM_REQ bus masters and a shared resource. It has a single clock domain.

## Interface
- NUM_REQ, default 4: number of requesters, ≥2.
- HOLD_MAX, default 16: maximum contended tenure in cycles, ≥2. Used only with RRA_HOLD_LIMIT_EN.
- ID_W, default $clog2(NUM_REQ): width of gnt_id. Derived; not overridden.
- clock  input  1  rising-edge clock. The block has one clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request per master; a master holds it high for the whole transaction.
- gnt  output  NUM_REQ  registered one-hot grant, or all-zero.
- gnt_id  output  ID_W  index of the granted master; 0 when gnt_valid=0.
- gnt_valid  output  1  equals |gnt.
- preempt  output  1  one-cycle pulse, registered with the grant it accompanies.

## Operation
- State: gnt register, last-winner pointer `last` (ID_W bits), and hold counter `hcnt` (only with the macro).
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, preempt=0, last=NUM_REQ-1, hcnt=0.
- States:
  - IDLE when gnt=0.
  - OWNED(i) when gnt[i]=1.
- Winner search: the first set req bit, scanning circularly from last+1. This gives req[0] top priority after reset.
- At each rising edge, outside reset:
  - **IDLE, req==0:** stay in IDLE.
  - **IDLE, req≠0:** go to OWNED(winner). Set last=winner and hcnt=0.
  - **OWNED(i), req[i]=1, no preemption:** hold the grant. hcnt increments and saturates at HOLD_MAX-1.
  - **OWNED(i), req[i]=0:** rearbitrate among the current req bits in the same edge. There is no bubble cycle.
    - If the search finds a winner, go to OWNED(winner), set last=winner and hcnt=0.
    - Otherwise go to IDLE.
- Preemption (macro only): it fires when all three conditions hold at an edge:
  - state is OWNED(i);
  - req[i]=1 and hcnt==HOLD_MAX-1;
  - (req & ~(1<<i)) ≠ 0.
  - On firing, the block arbitrates among the other requesters only. Master i is last, so it has lowest priority next time.
  - On firing, the block sets hcnt=0 and drives preempt=1 for that one registered cycle.
- A lone holder with no competitors is never preempted. hcnt stays saturated. A competitor that arrives later takes the bus at the next edge.
- A req pulse of a master that never owned the bus is simply lost if it drops before it is granted. The block has no request queue.
- gnt is always one-hot or zero. gnt_id and gnt_valid are derived from the same register, so they are coherent in every cycle.

## Timing
- Grant latency: 1 cycle. A req sampled at edge k with the bus free gives gnt high in the cycle after edge k.
- Release: a holder's req sampled low at edge k gives its gnt low after edge k. The next winner's gnt rises after the same edge.
- Contended tenure with the macro: exactly HOLD_MAX cycles of gnt high, then a handoff.
- Reset takes priority over all other behaviour. Reset asserted mid-tenure clears all state at the next edge, with no handoff and no preempt.
- There are no combinational paths from req to any output.

## Configuration
- RRA_HOLD_LIMIT_EN:
  - Defined: hcnt exists, preemption works as above, and preempt is live.
  - Undefined: hcnt logic is absent and preempt is tied to 0. A holder keeps the grant until it drops req, and HOLD_MAX is ignored.

## Test plan
All scenarios use NUM_REQ=4 and HOLD_MAX=4.
1. Hold reset for 5 cycles with req=4'b1111, then check outputs. Required: gnt=0, gnt_id=0, gnt_valid=0 and preempt=0 throughout. On the first edge after release, gnt=4'b0001.
2. Drive req=4'b0100 for 3 cycles, then 0. Required: gnt=4'b0100 and gnt_id=2 from 1 cycle after assertion. gnt stays set for 3 cycles and clears one cycle after req drops.
3. Run requesters that each drop req 1 cycle after being granted, with all four re-requesting. Required: grant order 0,1,2,3,0 with no idle cycle between grants.
4. Hold req=4'b0011 steadily with the macro on. Required: gnt0 for 4 cycles, then gnt1 for 4 cycles with preempt=1 in its first cycle, then gnt0 again. With the macro off: gnt0 for the whole run and preempt=0.
5. Hold req=4'b1000 steadily for 20 cycles with the macro on. Required: gnt=4'b1000 throughout and preempt never 1. Then add req[0]=1. Required: handoff to gnt0 at the next edge with preempt=1.
6. Assert reset for 1 cycle while gnt=4'b0100, then drive req=4'b1111. Required: gnt=0 after reset. The next grant is master 0, because last has reset to 3.
